inert_sensor_resp: RTL

SPI responder that models the inertial sensor at the far end of the inertial interface's 16-bit SPI link. It accepts configuration writes, serves data-register reads from a snapshot of externally supplied rate/acceleration samples, and raises INT when a new snapshot is ready. It is used in the bench and in FPGA loopback builds in place of the physical sensor.

---
 rtl/inert_resp_pkg.sv | 43 ++++
 rtl/spi_resp16.sv | 159 +++++++++++++++
 rtl/inert_sensor_resp.sv | 138 +++++++++++++
 3 files changed

// File: rtl/inert_resp_pkg.sv
// Shared constants and types for the inertial sensor SPI responder model.
package inert_resp_pkg;

    // Writable configuration registers
    localparam logic [6:0] ADDR_INT_CTRL  = 7'h0D;
    localparam logic [6:0] ADDR_ACCL_CFG  = 7'h10;
    localparam logic [6:0] ADDR_GYRO_CFG  = 7'h11;
    localparam logic [6:0] ADDR_ROUND_CFG = 7'h14;

    // Read-only snapshot registers (low byte at even address)
    localparam logic [6:0] ADDR_PTCH_L = 7'h22;
    localparam logic [6:0] ADDR_PTCH_H = 7'h23;
    localparam logic [6:0] ADDR_ROLL_L = 7'h24;
    localparam logic [6:0] ADDR_ROLL_H = 7'h25;
    localparam logic [6:0] ADDR_YAW_L  = 7'h26;
    localparam logic [6:0] ADDR_YAW_H  = 7'h27;
    localparam logic [6:0] ADDR_AX_L   = 7'h28;
    localparam logic [6:0] ADDR_AX_H   = 7'h29;
    localparam logic [6:0] ADDR_AY_L   = 7'h2A;
    localparam logic [6:0] ADDR_AY_H   = 7'h2B;

    // Frame layout: R/W, 7-bit address, 8-bit data
    localparam int FRM_RW_BIT   = 15;
    localparam int FRM_ADDR_MSB = 14;
    localparam int FRM_ADDR_LSB = 8;
    localparam int FRM_DATA_MSB = 7;

    // Rise counts marking the end of the header and of the frame
    localparam logic [4:0] BITS_HDR   = 5'd8;
    localparam logic [4:0] BITS_FRAME = 5'd16;
    localparam logic [4:0] BITS_SAT   = 5'd31;

    // Bit of INT_CTRL that enables snapshot capture / INT
    localparam int INT_EN_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR     = 2'd1,
        ST_DATA     = 2'd2,
        ST_WAIT_END = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_resp16.sv
// 16-bit mode-3 SPI responder front end: synchronizes the pins, frames
// address/data, shifts read data out and flags committed or broken frames.
module spi_resp16
    import inert_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ss_n,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic [7:0] i_rd_data,
    output logic       o_miso,
    output logic [6:0] o_addr,
    output logic [7:0] o_wr_data,
    output logic       o_is_rd,
    output logic       o_commit,
    output logic       o_frm_err
);

    logic       r_ss_meta, r_ss_sync, r_ss_d;
    logic       r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic       r_mosi_meta, r_mosi_sync;
    spi_state_t r_state;
    logic [4:0] r_bit_cnt;
    logic [15:0] r_rx;
    logic [7:0] r_tx;
    logic [6:0] r_addr;
    logic       r_is_rd;
    logic       r_load;
    logic       r_commit;
    logic       r_frm_err;
    logic       r_miso;

    logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;

    // SS_n sync flops clear to low so a select held low through reset
    // produces no fall edge: a frame starts only after SS_n is seen high.
    assign w_ss_fall   = r_ss_d & ~r_ss_sync;
    assign w_ss_rise   = ~r_ss_d & r_ss_sync;
    assign w_sclk_rise = r_sclk_sync & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_d;

    // Two-flop synchronizers plus one edge-detect stage for the SPI pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_meta   <= 1'b0;
            r_ss_sync   <= 1'b0;
            r_ss_d      <= 1'b0;
            r_sclk_meta <= 1'b1;
            r_sclk_sync <= 1'b1;
            r_sclk_d    <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_ss_meta   <= i_ss_n;
            r_ss_sync   <= r_ss_meta;
            r_ss_d      <= r_ss_sync;
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // Frame FSM: counts SCLK rises, latches header, flags commit or error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 5'd0;
            r_rx      <= 16'h0000;
            r_addr    <= 7'h00;
            r_is_rd   <= 1'b0;
            r_load    <= 1'b0;
            r_commit  <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_load    <= 1'b0;
            r_commit  <= 1'b0;
            r_frm_err <= 1'b0;
            if (w_ss_rise) begin
                if ((r_state == ST_WAIT_END) && (r_bit_cnt == BITS_FRAME)) begin
                    r_commit <= 1'b1;
                end else if (r_state != ST_IDLE) begin
                    r_frm_err <= 1'b1;
                end
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall) begin
                            r_state   <= ST_ADDR;
                            r_bit_cnt <= 5'd0;
                            r_rx      <= 16'h0000;
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_rx      <= {r_rx[14:0], r_mosi_sync};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == (BITS_HDR - 5'd1)) begin
                                r_state <= ST_DATA;
                                r_addr  <= {r_rx[5:0], r_mosi_sync};
                                r_is_rd <= r_rx[6];
                                r_load  <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_rx      <= {r_rx[14:0], r_mosi_sync};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == (BITS_FRAME - 5'd1)) begin
                                r_state <= ST_WAIT_END;
                            end
                        end
                    end
                    ST_WAIT_END: begin
                        // Extra rises make the frame over-length
                        if (w_sclk_rise && (r_bit_cnt != BITS_SAT)) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Transmit path: load read byte after the header, shift it out on falls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= 8'h00;
            r_miso <= 1'b0;
        end else if (w_ss_rise) begin
            r_tx   <= 8'h00;
            r_miso <= 1'b0;
        end else if (r_load) begin
            r_tx <= r_is_rd ? i_rd_data : 8'h00;
        end else if (w_sclk_fall) begin
            if (r_state == ST_DATA) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

    assign o_miso    = r_miso;
    assign o_addr    = r_addr;
    assign o_wr_data = r_rx[FRM_DATA_MSB:0];
    assign o_is_rd   = r_is_rd;
    assign o_commit  = r_commit;
    assign o_frm_err = r_frm_err;

endmodule

// File: rtl/inert_sensor_resp.sv
// Inertial sensor stand-in: configuration registers, sample snapshot with
// lock/INT handshake and overrun counter behind a 16-bit SPI responder.
module inert_sensor_resp
    import inert_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic        smpl_vld,
    input  logic [15:0] ptch_rt,
    input  logic [15:0] roll_rt,
    input  logic [15:0] yaw_rt,
    input  logic [15:0] ax,
    input  logic [15:0] ay,
    output logic        int_en,
    output logic [7:0]  ovr_cnt,
    output logic        frm_err
);

    logic [6:0]  w_addr;
    logic [7:0]  w_wr_data;
    logic        w_is_rd;
    logic        w_commit;
    logic [7:0]  w_rd_data;
    logic        w_int_clr, w_lock_clr, w_lock_eff, w_accept, w_drop;

    logic [7:0]  r_int_ctrl, r_accl_cfg, r_gyro_cfg, r_round_cfg;
    logic [15:0] r_ptch, r_roll, r_yaw, r_ax, r_ay;
    logic        r_int, r_lock;
    logic [7:0]  r_ovr_cnt;

    spi_resp16 u_spi (
        .clk       (clk),
        .rst       (rst),
        .i_ss_n    (SS_n),
        .i_sclk    (SCLK),
        .i_mosi    (MOSI),
        .i_rd_data (w_rd_data),
        .o_miso    (MISO),
        .o_addr    (w_addr),
        .o_wr_data (w_wr_data),
        .o_is_rd   (w_is_rd),
        .o_commit  (w_commit),
        .o_frm_err (frm_err)
    );

    // Read data mux for the addressed register
    always_comb begin
        w_rd_data = 8'h00;
        case (w_addr)
            ADDR_INT_CTRL:  w_rd_data = r_int_ctrl;
            ADDR_ACCL_CFG:  w_rd_data = r_accl_cfg;
            ADDR_GYRO_CFG:  w_rd_data = r_gyro_cfg;
            ADDR_ROUND_CFG: w_rd_data = r_round_cfg;
            ADDR_PTCH_L:    w_rd_data = r_ptch[7:0];
            ADDR_PTCH_H:    w_rd_data = r_ptch[15:8];
            ADDR_ROLL_L:    w_rd_data = r_roll[7:0];
            ADDR_ROLL_H:    w_rd_data = r_roll[15:8];
            ADDR_YAW_L:     w_rd_data = r_yaw[7:0];
            ADDR_YAW_H:     w_rd_data = r_yaw[15:8];
            ADDR_AX_L:      w_rd_data = r_ax[7:0];
            ADDR_AX_H:      w_rd_data = r_ax[15:8];
            ADDR_AY_L:      w_rd_data = r_ay[7:0];
            ADDR_AY_H:      w_rd_data = r_ay[15:8];
            default:        w_rd_data = 8'h00;
        endcase
    end

    // Reading the low pitch byte acknowledges INT; reading the last byte
    // releases the snapshot. Release wins over a coincident sample.
    assign w_int_clr  = w_commit & w_is_rd & (w_addr == ADDR_PTCH_L);
    assign w_lock_clr = w_commit & w_is_rd & (w_addr == ADDR_AY_H);
    assign w_lock_eff = r_lock & ~w_lock_clr;
    assign w_accept   = smpl_vld & int_en & ~w_lock_eff;
    assign w_drop     = smpl_vld & int_en & w_lock_eff;

    // Configuration register writes on committed write frames
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_ctrl  <= 8'h00;
            r_accl_cfg  <= 8'h00;
            r_gyro_cfg  <= 8'h00;
            r_round_cfg <= 8'h00;
        end else if (w_commit && !w_is_rd) begin
            case (w_addr)
                ADDR_INT_CTRL:  r_int_ctrl  <= w_wr_data;
                ADDR_ACCL_CFG:  r_accl_cfg  <= w_wr_data;
                ADDR_GYRO_CFG:  r_gyro_cfg  <= w_wr_data;
                ADDR_ROUND_CFG: r_round_cfg <= w_wr_data;
                default: begin
                end
            endcase
        end
    end

    // Snapshot capture, INT/lock handshake and saturating overrun count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptch    <= 16'h0000;
            r_roll    <= 16'h0000;
            r_yaw     <= 16'h0000;
            r_ax      <= 16'h0000;
            r_ay      <= 16'h0000;
            r_int     <= 1'b0;
            r_lock    <= 1'b0;
            r_ovr_cnt <= 8'h00;
        end else begin
            if (w_accept) begin
                r_ptch <= ptch_rt;
                r_roll <= roll_rt;
                r_yaw  <= yaw_rt;
                r_ax   <= ax;
                r_ay   <= ay;
                r_int  <= 1'b1;
                r_lock <= 1'b1;
            end else begin
                if (w_lock_clr) begin
                    r_lock <= 1'b0;
                end
                if (w_int_clr) begin
                    r_int <= 1'b0;
                end
            end
            if (w_drop && (r_ovr_cnt != 8'hFF)) begin
                r_ovr_cnt <= r_ovr_cnt + 8'h01;
            end
        end
    end

    assign int_en  = r_int_ctrl[INT_EN_BIT];
    assign INT     = r_int;
    assign ovr_cnt = r_ovr_cnt;

endmodule
